// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, RAM-wait freezes.
// Optional HAZARD_STATS_EN macro adds saturating stall_cycles / flush_events counters.
module pipeline_hazard_controller #(
  parameter int LOAD_USE_STALL_CYCLES = 1,
  parameter int CNT_W                 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs1_address,
  input  logic [4:0] id_rs2_address,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd_address,
  input  logic       ex_reg_wren,
  input  logic       ex_is_load,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_wren,
  output logic       if_id_wren,
  output logic       id_ex_wren,
  output logic       ex_mem_wren,
  output logic       mem_wb_wren,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       stalled
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LOAD_USE_STALL_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_freeze;
  logic             w_hazard;
  logic             w_branch_flush;

  assign w_freeze = mem_req & ~mem_ready;

  // x0 is hardwired zero, so a load targeting it can never create a dependency
  assign w_hazard = ex_is_load & ex_reg_wren & (ex_rd_address != 5'd0) &
                    ((id_uses_rs1 & (id_rs1_address == ex_rd_address)) |
                     (id_uses_rs2 & (id_rs2_address == ex_rd_address)));

  assign w_branch_flush = reset_n & ~w_freeze & ex_branch_taken;

  always_comb begin
    pc_wren     = 1'b1;
    if_id_wren  = 1'b1;
    id_ex_wren  = 1'b1;
    ex_mem_wren = 1'b1;
    mem_wb_wren = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    stalled     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!reset_n) begin
      pc_wren     = 1'b0;
      if_id_wren  = 1'b0;
      id_ex_wren  = 1'b0;
      ex_mem_wren = 1'b0;
      mem_wb_wren = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else if (w_freeze) begin
      pc_wren     = 1'b0;
      if_id_wren  = 1'b0;
      id_ex_wren  = 1'b0;
      ex_mem_wren = 1'b0;
      mem_wb_wren = 1'b0;
      stalled     = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        LU_STALL: begin
          pc_wren     = 1'b0;
          if_id_wren  = 1'b0;
          id_ex_flush = 1'b1;
          stalled     = 1'b1;
          w_cnt_nxt   = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          // cnt<=1 also exits so a corrupted zero count cannot lock the pipe
          if (r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = LU_STALL;
          end
        end
        RUN: begin
          if (w_hazard) begin
            pc_wren     = 1'b0;
            if_id_wren  = 1'b0;
            id_ex_flush = 1'b1;
            stalled     = 1'b1;
            if (LOAD_USE_STALL_CYCLES > 1) begin
              w_state_nxt = LU_STALL;
              w_cnt_nxt   = LU_RELOAD;
            end else begin
              w_state_nxt = RUN;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  // Event counters saturate rather than wrap so a long run never reads as a short one
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (stalled && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if (w_branch_flush && (r_flush_events != 32'hFFFF_FFFF)) begin
        r_flush_events <= r_flush_events + 32'd1;
      end else begin
        r_flush_events <= r_flush_events;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers, plus PC).
- Detects load-use hazards, taken branches/jumps and multi-cycle data-RAM accesses.
- Drives the per-register wren and flush strobes; flush with wren=1 loads a bubble (all zero).

Parameters:
LOAD_USE_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..15
CNT_W, 4, width of the internal stall down-counter

Ports:
clk  input  1  clock
reset_n  input  1  reset
id_rs1_address  input  5  rs1 index of instruction in ID
id_rs2_address  input  5  rs2 index of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd_address  input  5  rd of instruction in EX (ID/EX output)
ex_reg_wren  input  1  EX instruction writes a register
ex_is_load  input  1  EX instruction's write data comes from RAM
ex_branch_taken  input  1  EX resolved a taken branch/jump; PC target valid this cycle
mem_req  input  1  MEM stage has a RAM access in progress
mem_ready  input  1  RAM access completes this cycle
pc_wren  output  1  PC update enable
if_id_wren  output  1  IF/ID enable
id_ex_wren  output  1  ID/EX enable
ex_mem_wren  output  1  EX/MEM enable
mem_wb_wren  output  1  MEM/WB enable
if_id_flush  output  1  load bubble into IF/ID
id_ex_flush  output  1  load bubble into ID/EX
stalled  output  1  any freeze or load-use stall active this cycle

Behaviour:
- Reset: reset_n synchronous, active-low; clock clk.
  - While reset_n=0: all wren outputs 0, both flush outputs 1, stalled 0.
  - Registered state returns to RUN and the counter clears to 0.
- Registered state: RUN, LU_STALL, and counter cnt. All outputs are combinational from the state and the current inputs, giving zero-latency control.
- Default output values: all wren 1, flush 0, stalled 0.
- Priority: memory freeze, then branch, then load-use.
- Memory freeze (any state): mem_req=1 and mem_ready=0.
  - All five wren outputs 0, flush 0, stalled 1.
  - State and cnt hold.
  - In the mem_ready=1 cycle, normal rules for the current state apply.
- Branch (no freeze, ex_branch_taken=1):
  - pc_wren=1, if_id_flush=1, id_ex_flush=1, all wren 1.
  - Next state RUN, cnt←0. Overrides any coincident load-use hazard.
- Load-use hazard, RUN only: ex_is_load & ex_reg_wren & ex_rd_address≠0 & ((id_uses_rs1 & id_rs1_address==ex_rd_address) | (id_uses_rs2 & id_rs2_address==ex_rd_address)).
  - Outputs: pc_wren=0, if_id_wren=0, id_ex_wren=1, id_ex_flush=1, ex_mem_wren=1, mem_wb_wren=1, stalled=1.
  - If LOAD_USE_STALL_CYCLES>1: next state LU_STALL, cnt←LOAD_USE_STALL_CYCLES-1. Otherwise stay in RUN.
- LU_STALL (no freeze):
  - Same outputs as a load-use hazard.
  - cnt decrements each cycle. When cnt==1, next state is RUN.
  - The hazard check is not re-evaluated in this state.
- rd=x0 never causes a stall. Both sources matching counts as one hazard.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Extra outputs stall_cycles[31:0] and flush_events[31:0], both reset to 0 and saturating at 0xFFFFFFFF.
  - stall_cycles increments every cycle with stalled=1.
  - flush_events increments every branch flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset held 3 cycles, then released with idle inputs → during reset all wren=0, flushes=1; after release all wren=1, flush=0, stalled=0.
- Load hazard (ex_is_load=1, ex_reg_wren=1, ex_rd=5, id_rs2=5, id_uses_rs2=1), default parameter → exactly 1 cycle with pc_wren=0, if_id_wren=0, id_ex_flush=1; ex_rd=0 with the same stimulus → no stall.
- LOAD_USE_STALL_CYCLES=3, hazard pulsed for 1 cycle → stalled=1 for exactly 3 consecutive cycles, then RUN.
- ex_branch_taken=1 coincident with a load-use match → pc_wren=1, if_id_flush=1, id_ex_flush=1, no stall; next state RUN.
- mem_req=1, mem_ready=0 for 4 cycles arriving in the 2nd cycle of a 3-cycle LU_STALL → all wren 0 for 4 cycles, cnt held; after mem_ready the remaining 2 stall cycles complete.
- With HAZARD_STATS_EN: 2 branches plus a 3-cycle load stall → flush_events=2, stall_cycles=3; preload near 0xFFFFFFFF → counter saturates, does not wrap.
